trace_tx: RTL

Hardware transmitter for the processor's per-cycle commit trace. Accepts one commit-event bundle per cycle from the writeback/memory stages (register write, load, store, halt). Buffers bundles and serializes each into a 16-bit word stream with a valid/ready handshake. The stream carries the same REG/LOAD/STORE/HALT records the simulation trace prints, so an off-chip or FPGA host can rebuild `verilogsim.ptrace` without a simulator.

---
 rtl/trace_pkg.sv | 69 ++++++
 rtl/trace_fifo.sv | 45 ++++
 rtl/trace_tx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the commit-trace transmitter: record codes, serializer
// states, the buffered bundle layout and the word/sequence helpers.
package trace_pkg;

    localparam logic [3:0] TYPE_REG   = 4'd1;
    localparam logic [3:0] TYPE_LOAD  = 4'd2;
    localparam logic [3:0] TYPE_STORE = 4'd3;
    localparam logic [3:0] TYPE_HALT  = 4'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_HEAD,
        S_REG_H, S_REG_D,
        S_LD_H, S_LD_A, S_LD_D,
        S_ST_H, S_ST_A, S_ST_D,
        S_HLT_H, S_HLT_I, S_HLT_C,
        S_DONE
    } state_e;

    // Flags and register index first, then the 16-bit payload fields.
    typedef struct packed {
        logic        regwrt;
        logic        memrd;
        logic        memwr;
        logic        halt;
        logic [2:0]  wreg;
        logic [15:0] wdata;
        logic [15:0] addr;
        logic [15:0] mdata;
        logic [15:0] instCount;
        logic [15:0] cycleCount;
    } bundle_t;

    localparam int BUNDLE_W = $bits(bundle_t);

    // First record header at or after the given record slot (0=REG .. 3=HALT);
    // S_IDLE means the bundle has nothing further to send.
    function automatic state_e nextRecord(bundle_t b, logic [1:0] stage);
        state_e s;
        s = S_IDLE;
        if (stage == 2'd0 && b.regwrt)
            s = S_REG_H;
        else if (stage <= 2'd1 && b.memrd)
            s = S_LD_H;
        else if (stage <= 2'd2 && b.memwr)
            s = S_ST_H;
        else if (b.halt)
            s = S_HLT_H;
        return s;
    endfunction

    function automatic logic [15:0] wordFor(bundle_t b, state_e s);
        logic [15:0] w;
        w = '0;
        case (s)
            S_REG_H:        w = {TYPE_REG, 9'd0, b.wreg};
            S_REG_D:        w = b.wdata;
            S_LD_H:         w = {TYPE_LOAD, 12'd0};
            S_ST_H:         w = {TYPE_STORE, 12'd0};
            S_LD_A, S_ST_A: w = b.addr;
            S_LD_D, S_ST_D: w = b.mdata;
            S_HLT_H:        w = {TYPE_HALT, 12'd0};
            S_HLT_I:        w = b.instCount;
            S_HLT_C:        w = b.cycleCount;
            default:        w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO with full/empty flags; the head entry is
// visible on rdata_o whenever the FIFO is non-empty.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;

    // The extra pointer bit separates the full case from the empty case.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o)
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && !full_o)
                wptr_q <= wptr_q + 1'b1;
            if (pop_i && !empty_o)
                rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/trace_tx.sv
// Commit-trace transmitter: snapshots commit bundles with cycle/instruction
// counts, buffers them and serializes REG/LOAD/STORE/HALT records as 16-bit words.
module trace_tx
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        ev_regwrt_i,
    input  logic [2:0]  ev_wreg_i,
    input  logic [15:0] ev_wdata_i,
    input  logic        ev_memrd_i,
    input  logic        ev_memwr_i,
    input  logic [15:0] ev_addr_i,
    input  logic [15:0] ev_mdata_i,
    input  logic        ev_halt_i,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [15:0] tx_data_o,
    output logic        tx_last_o,
    output logic        done_o
);

    logic [15:0] cycleCount_q, cycleCount_d;
    logic [15:0] instCount_q, instCount_d;
    logic        haltSeen_q;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifoFull;
    logic        fifoEmpty;
    bundle_t     pushBundle;
    bundle_t     headBundle;
    bundle_t     cur_q;
    state_e      state_q;
    state_e      succ;
    state_e      firstRec;
    logic        txValid_q;
    logic [15:0] txData_q;
    logic        txLast_q;
    logic        done_q;

    assign in_ready_o = !fifoFull && !haltSeen_q;
    assign accept     = in_valid_i && in_ready_o;
    assign pop        = (state_q == S_LOAD_HEAD);
    assign tx_valid_o = txValid_q;
    assign tx_data_o  = txData_q;
    assign tx_last_o  = txLast_q;
    assign done_o     = done_q;

    // Snapshots carry the counter values as they stand after the accepting edge.
    always_comb begin
        cycleCount_d = cycleCount_q + 16'd1;
        instCount_d  = instCount_q;
        if (accept && (ev_halt_i || ev_regwrt_i || ev_memwr_i))
            instCount_d = instCount_q + 16'd1;

        pushBundle.regwrt     = ev_regwrt_i;
        pushBundle.memrd      = ev_memrd_i;
        pushBundle.memwr      = ev_memwr_i;
        pushBundle.halt       = ev_halt_i;
        pushBundle.wreg       = ev_wreg_i;
        pushBundle.wdata      = ev_wdata_i;
        pushBundle.addr       = ev_addr_i;
        pushBundle.mdata      = ev_mdata_i;
        pushBundle.instCount  = instCount_d;
        pushBundle.cycleCount = cycleCount_d;

        push = accept && (ev_regwrt_i || ev_memrd_i || ev_memwr_i || ev_halt_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycleCount_q <= '0;
            instCount_q  <= '0;
            haltSeen_q   <= 1'b0;
        end else begin
            cycleCount_q <= cycleCount_d;
            instCount_q  <= instCount_d;
            if (accept && ev_halt_i)
                haltSeen_q <= 1'b1;
        end
    end

    trace_fifo #(
        .WIDTH (BUNDLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (pushBundle),
        .pop_i   (pop),
        .rdata_o (headBundle),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    always_comb begin
        firstRec = nextRecord(headBundle, 2'd0);
        succ     = state_q;
        case (state_q)
            S_REG_H: succ = S_REG_D;
            S_REG_D: succ = nextRecord(cur_q, 2'd1);
            S_LD_H:  succ = S_LD_A;
            S_LD_A:  succ = S_LD_D;
            S_LD_D:  succ = nextRecord(cur_q, 2'd2);
            S_ST_H:  succ = S_ST_A;
            S_ST_A:  succ = S_ST_D;
            S_ST_D:  succ = nextRecord(cur_q, 2'd3);
            S_HLT_H: succ = S_HLT_I;
            S_HLT_I: succ = S_HLT_C;
            S_HLT_C: succ = S_DONE;
            default: succ = state_q;
        endcase
    end

    // succ == S_IDLE marks the end of the current bundle's records.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            txValid_q <= 1'b0;
            txData_q  <= '0;
            txLast_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifoEmpty)
                        state_q <= S_LOAD_HEAD;
                end
                S_LOAD_HEAD: begin
                    cur_q     <= headBundle;
                    state_q   <= firstRec;
                    txValid_q <= (firstRec != S_IDLE);
                    txData_q  <= wordFor(headBundle, firstRec);
                    txLast_q  <= 1'b0;
                end
                S_DONE: begin
                    txValid_q <= 1'b0;
                end
                default: begin
                    if (txValid_q && tx_ready_i) begin
                        if (succ == S_DONE) begin
                            state_q   <= S_DONE;
                            txValid_q <= 1'b0;
                            txLast_q  <= 1'b0;
                            done_q    <= 1'b1;
                        end else if (succ == S_IDLE) begin
                            state_q   <= fifoEmpty ? S_IDLE : S_LOAD_HEAD;
                            txValid_q <= 1'b0;
                            txLast_q  <= 1'b0;
                        end else begin
                            state_q  <= succ;
                            txData_q <= wordFor(cur_q, succ);
                            txLast_q <= (succ == S_HLT_C);
                        end
                    end
                end
            endcase
        end
    end

endmodule
